// File: rtl/minority_pkg.sv
// rtl/minority_pkg.sv - shared types, constants and golden function for the minority self-test
//
// Contents:
//   mc_state_t    : sequencer states IDLE, WAIT, CHECK, DONE
//   NUM_VEC       : number of input vectors swept per run
//   minority_exp  : expected minority output for a {a,b,c} vector
package minority_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} mc_state_t;

    localparam int NUM_VEC = 8;

    // 1 when at most one of the three inputs is 1.
    function automatic logic minority_exp(logic [2:0] v);
        return ~((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/minority_checker_if.sv
// rtl/minority_checker_if.sv - stimulus/response bus between the checker and the gate under test
//
// Signals:
//   a, b, c : stimulus inputs of the gate
//   y       : gate output
// Modports:
//   master  : checker side (drives a/b/c, observes y)
//   slave   : gate side (observes a/b/c, drives y)
interface minority_checker_if;

    logic a;
    logic b;
    logic c;
    logic y;

    modport master (output a, output b, output c, input y);
    modport slave  (input a, input b, input c, output y);

endinterface

// File: rtl/minority_ref.sv
// rtl/minority_ref.sv - combinational golden model of the minority gate
//
// Ports:
//   vec   in  3 : input vector {a,b,c}
//   exp_y out 1 : expected gate output for vec
module minority_ref
    import minority_pkg::*;
(
    input  logic [2:0] vec,
    output logic       exp_y
);

    assign exp_y = minority_exp(vec);

endmodule

// File: rtl/minority_checker.sv
// rtl/minority_checker.sv - self-test sequencer sweeping all eight vectors through a minority gate
//
// Parameters:
//   SETTLE          : cycles each vector is held before y is sampled (1..15)
// Ports:
//   clk             in  1 : clock, rising edge
//   reset           in  1 : synchronous, active-high
//   start           in  1 : level, sampled only in IDLE, launches one run
//   gate            master: a/b/c stimulus out, y response in
//   busy            out 1 : run in progress (WAIT or CHECK)
//   done            out 1 : one-cycle pulse at end of run
//   pass            out 1 : last completed run had no mismatches
//   err_count       out 4 : mismatching vectors in current/last run
//   fail_valid      out 1 : at least one mismatch in current/last run
//   fail_vec        out 3 : first mismatching vector
module minority_checker
    import minority_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    minority_checker_if.master        gate,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [3:0]                err_count,
    output logic                      fail_valid,
    output logic [2:0]                fail_vec
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("minority_checker: SETTLE must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] VEC_LAST = 3'(NUM_VEC - 1);

    mc_state_t  state;
    mc_state_t  next_state;
    logic [2:0] vec;
    logic [3:0] cnt;
    logic       exp_y;
    logic       mismatch;

    minority_ref u_ref (
        .vec   (vec),
        .exp_y (exp_y)
    );

    // The vector register is the stimulus itself, so a/b/c stay at the
    // last vector (3'b111) after a run until the next start clears it.
    assign gate.a = vec[2];
    assign gate.b = vec[1];
    assign gate.c = vec[0];

    assign mismatch = (gate.y != exp_y);
    assign busy     = (state == WAIT) || (state == CHECK);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WAIT;
            WAIT:    if (cnt == CNT_LAST) next_state = CHECK;
            CHECK:   next_state = (vec == VEC_LAST) ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= 3'd0;
            cnt        <= 4'd0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= 3'd0;
                        cnt        <= 4'd0;
                        err_count  <= 4'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 3'd0;
                        pass       <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    // At most eight mismatches fit in four bits, no saturation needed.
                    if (mismatch) begin
                        err_count <= err_count + 4'd1;
                        if (!fail_valid) begin
                            fail_vec   <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec != VEC_LAST) begin
                        vec <= vec + 3'd1;
                        cnt <= 4'd0;
                    end
                end
                DONE: begin
                    // err_count already includes the vector-7 result from CHECK.
                    pass <= (err_count == 4'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minority_checker.sv
// tb/tb_minority_checker.sv - self-checking bench for minority_checker
module tb_minority_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, start0, reset1, start1;
    logic [7:0] tbl0, tbl1;
    logic       busy0, done0, pass0, fv0;
    logic       busy1, done1, pass1, fv1;
    logic [3:0] err0, err1;
    logic [2:0] fvec0, fvec1;

    int checks = 0;
    int errors = 0;

    minority_checker_if g0 ();
    minority_checker_if g1 ();

    // Gate under test modelled as a truth table indexed by {a,b,c}.
    assign g0.y = tbl0[{g0.a, g0.b, g0.c}];
    assign g1.y = tbl1[{g1.a, g1.b, g1.c}];

    minority_checker #(.SETTLE(2)) dut0 (
        .clk        (clk),
        .reset      (reset0),
        .start      (start0),
        .gate       (g0.master),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .err_count  (err0),
        .fail_valid (fv0),
        .fail_vec   (fvec0)
    );

    minority_checker #(.SETTLE(1)) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .start      (start1),
        .gate       (g1.master),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err1),
        .fail_valid (fv1),
        .fail_vec   (fvec1)
    );

    // Reference: count vectors where the table disagrees with "at most one input set".
    task automatic model(input logic [7:0] tbl, output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            logic       expv;
            vv   = 3'(v);
            expv = ($countones(vv) <= 1);
            if (tbl[v] != expv) begin
                if (errs == 0) first = v;
                errs++;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset0 = 1'b1; reset1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        tbl0 = 8'h17;  tbl1 = 8'h17;
        tick(); tick();
        checks++;
        if ({busy0, done0, pass0, err0, fv0, fvec0, g0.a, g0.b, g0.c} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dut0: got %b want 0", {busy0, done0, pass0, err0, fv0, fvec0, g0.a, g0.b, g0.c});
        end
        checks++;
        if ({busy1, done1, pass1, err1, fv1, fvec1, g1.a, g1.b, g1.c} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %b want 0", {busy1, done1, pass1, err1, fv1, fvec1, g1.a, g1.b, g1.c});
        end
        reset0 = 1'b0; reset1 = 1'b0;
        tick();
    endtask

    // One SETTLE=2 run on dut0; start is a one-cycle pulse at cycle 0,
    // with an optional extra pulse at cycle pulse_at that must be ignored.
    task automatic run0(input string name, input logic [7:0] tbl, input int exp_err,
                        input int exp_first, input int pulse_at);
        tbl0   = tbl;
        start0 = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            logic [4:0] want, got;
            int         v;
            tick();
            start0 = (c == pulse_at);
            v      = (c <= 24) ? (c - 1) / 3 : 7;
            want   = {1'(c <= 24), 1'(c == 25), 3'(v)};
            got    = {busy0, done0, g0.a, g0.b, g0.c};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_timing c=%0d: busy/done/abc got %b want %b", name, c, got, want);
            end
            if (c == 26) begin
                checks++;
                if (err0 !== 4'(exp_err)) begin
                    errors++;
                    $display("FAIL %s_err_count: got %0d want %0d", name, err0, exp_err);
                end
                checks++;
                if (pass0 !== (exp_err == 0) || fv0 !== (exp_err != 0)) begin
                    errors++;
                    $display("FAIL %s_pass_fv: got pass=%b fv=%b want pass=%b fv=%b",
                             name, pass0, fv0, exp_err == 0, exp_err != 0);
                end
                if (exp_err != 0) begin
                    checks++;
                    if (fvec0 !== 3'(exp_first)) begin
                        errors++;
                        $display("FAIL %s_fail_vec: got %0d want %0d", name, fvec0, exp_first);
                    end
                end
            end
        end
    endtask

    task automatic test_directed;
        run0("correct",  8'h17, 0, 0, 0);
        run0("tied0",    8'h00, 4, 0, 0);
        run0("tied1",    8'hFF, 4, 3, 0);
        run0("majority", 8'hE8, 8, 0, 0);
        run0("vec7only", 8'h97, 1, 7, 0);
    endtask

    task automatic test_start_ignored;
        run0("pulse_mid",  8'h00, 4, 0, 10);
        run0("pulse_done", 8'hFF, 4, 3, 25);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] t;
            int         e, f;
            t = 8'($urandom);
            model(t, e, f);
            run0($sformatf("rand%0d", i), t, e, f, 0);
        end
    endtask

    task automatic test_reset_midrun;
        tbl0   = 8'h00;
        start0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start0 = 1'b0;
        end
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        checks++;
        if ({busy0, done0, pass0, err0, fv0, fvec0, g0.a, g0.b, g0.c} !== 15'd0) begin
            errors++;
            $display("FAIL reset_midrun: got %b want 0", {busy0, done0, pass0, err0, fv0, fvec0, g0.a, g0.b, g0.c});
        end
        for (int c = 12; c <= 40; c++) begin
            tick();
            checks++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done c=%0d: done=%b busy=%b want 0 0", c, done0, busy0);
            end
        end
        run0("after_reset", 8'h17, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        tbl1   = 8'h00;
        start1 = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            logic [1:0] want, got;
            tick();
            want = {1'((c >= 1 && c <= 16) || (c >= 19 && c <= 34)), 1'(c == 17 || c == 35)};
            got  = {busy1, done1};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b_timing c=%0d: busy/done got %b want %b", c, got, want);
            end
            if (c == 18) begin
                checks++;
                if ({err1, fv1, pass1, g1.a, g1.b, g1.c} !== {4'd4, 1'b1, 1'b0, 3'd7}) begin
                    errors++;
                    $display("FAIL b2b_first_result: err=%0d fv=%b pass=%b abc=%0d want 4 1 0 7",
                             err1, fv1, pass1, {g1.a, g1.b, g1.c});
                end
            end
            if (c == 19) begin
                checks++;
                if ({err1, fv1, pass1, g1.a, g1.b, g1.c} !== 10'd0) begin
                    errors++;
                    $display("FAIL b2b_cleared: err=%0d fv=%b pass=%b abc=%0d want 0 0 0 0",
                             err1, fv1, pass1, {g1.a, g1.b, g1.c});
                end
                tbl1 = 8'h17;
            end
            if (c == 20) start1 = 1'b0;
            if (c == 36) begin
                checks++;
                if ({err1, fv1, pass1} !== {4'd0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_second_result: err=%0d fv=%b pass=%b want 0 0 1", err1, fv1, pass1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
